apb_gpio_v2: RTL and testbench
==============================

APB_GPIO_V2 -- requirements
Module: apb_gpio_v2

Interface
REQ-001 Parameter PDATA_SIZE, default 32: APB data and address width in bits; SHALL be 32.
REQ-002 Parameter NGPIO, default 32: number of GPIO pins, legal range 1..32; register bits [31:NGPIO] SHALL read 0 and ignore writes.
REQ-003 Parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..4.
REQ-004 Clocking SHALL be one clock, PCLK; reset SHALL be PRESETn, synchronous and active-low.
REQ-005 PCLK  input  1  APB clock; all state SHALL update on its rising edge.
REQ-006 PRESETn  input  1  synchronous active-low reset.
REQ-007 PSEL1  input  1  APB slave select.
REQ-008 PENABLE  input  1  APB access phase.
REQ-009 PADDR  input  PDATA_SIZE  byte address; only PADDR[4:0] SHALL be decoded.
REQ-010 PWRITE  input  1  1=write, 0=read.
REQ-011 PWDATA  input  PDATA_SIZE  write data.
REQ-012 PSTRB  input  PDATA_SIZE/8  byte-lane write strobes.
REQ-013 PRDATA  output  PDATA_SIZE  read data.
REQ-014 PREADY  output  1  transfer complete.
REQ-015 PSLVERR  output  1  error on unmapped address.
REQ-016 gpio_in  input  NGPIO  asynchronous pin inputs.
REQ-017 gpio_out  output  NGPIO  pin output values.
REQ-018 gpio_oe  output  NGPIO  pin output enables (1=drive).
REQ-019 irq  output  1  level interrupt, registered.

Function
REQ-020 Register map: 0x00 IN (RO), 0x04 OUT (RW), 0x08 DIR (RW, 1=output), 0x0C RISE_EN (RW), 0x10 FALL_EN (RW), 0x14 STATUS (RO, write-1-to-clear), 0x18 IRQ_MASK (RW, 1=enabled).
REQ-021 Transfer FSM states SHALL be IDLE, SETUP, ACCESS: IDLE->SETUP on PSEL1&!PENABLE; SETUP->ACCESS on PSEL1&PENABLE; ACCESS->SETUP if PSEL1&!PENABLE, else IDLE.
REQ-022 PREADY SHALL be registered: low in SETUP and high for exactly one cycle in ACCESS, giving one wait state per transfer (transfer completes on the second access-phase cycle).
REQ-023 Register writes and W1C clears SHALL take effect on the cycle PREADY is high with PWRITE=1; writes with PSEL1 or PENABLE low SHALL have no effect.
REQ-024 Writes SHALL update only byte lanes with PSTRB[n]=1; lanes with PSTRB[n]=0 SHALL retain their value (never X).
REQ-025 Reads SHALL drive PRDATA with PREADY; PRDATA SHALL be 0 outside read completion.
REQ-026 An address outside 0x00..0x18 or unaligned (PADDR[1:0]!=0) SHALL assert PSLVERR with PREADY, cause no state change, and return PRDATA=0.
REQ-027 A write to IN SHALL be ignored without error.
REQ-028 gpio_in SHALL pass through SYNC_STAGES flops; IN SHALL read the synchronised value for all pins regardless of DIR.
REQ-029 gpio_out SHALL equal OUT and gpio_oe SHALL equal DIR, both registered.
REQ-030 Edge detect SHALL compare the synchronised value with its one-cycle-delayed copy: a rise with RISE_EN[i]=1 or a fall with FALL_EN[i]=1 SHALL set STATUS[i] on the next edge.
REQ-031 If a W1C clear and a new edge on the same bit coincide, set SHALL win.
REQ-032 irq SHALL be registered |(STATUS & IRQ_MASK), one cycle after STATUS changes.
REQ-033 Pin-to-STATUS latency SHALL be SYNC_STAGES+1 cycles; to irq SHALL be SYNC_STAGES+2 cycles.

Reset
REQ-034 While PRESETn=0 at a PCLK edge, all registers, synchroniser and delay flops SHALL clear to 0; PREADY, PSLVERR, irq, PRDATA, gpio_out, gpio_oe SHALL be 0.
REQ-035 Reset asserted mid-transfer SHALL abort it with no register update; the FSM SHALL restart in IDLE.
REQ-036 No edge SHALL be detected on the first cycle after reset release from the 0 reset value of the delay flop unless the synchronised input is 1 (a pin held high through reset SHALL set STATUS only if RISE_EN was already 1, which reset prevents).

Verification
REQ-037 Write OUT=0xA5A5_5A5A, PSTRB=4'b0101, prior OUT=0 -> OUT reads 0x00A5_005A; gpio_out matches.
REQ-038 DIR=0xFFFF_0000 then read IN with gpio_in=0x1234_5678 held 3 cycles -> PRDATA=0x1234_5678, gpio_oe=0xFFFF_0000.
REQ-039 RISE_EN[3]=1, IRQ_MASK[3]=1, gpio_in[3] 0->1 -> STATUS=0x8 after 3 cycles, irq=1 after 4; write STATUS=0x8 -> irq=0 two cycles later.
REQ-040 W1C of STATUS[3] on the same cycle a new rising edge sets it -> STATUS[3] stays 1.
REQ-041 Read at PADDR=0x1C or 0x05 -> PSLVERR=1, PRDATA=0, no register change.
REQ-042 Assert PRESETn=0 during the ACCESS cycle of a write to DIR -> DIR=0, FSM IDLE, all outputs 0.

Source files
------------

// File: rtl/apb_gpio_v2.sv
// APB GPIO peripheral: pin I/O registers, synchronised inputs, edge-detect
// status with write-1-to-clear, and a masked, registered interrupt.
module apb_gpio_v2 #(
  parameter int PDATA_SIZE  = 32,
  parameter int NGPIO       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL1,
  input  logic                    PENABLE,
  input  logic [PDATA_SIZE-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic [NGPIO-1:0]        gpio_in,
  output logic [NGPIO-1:0]        gpio_out,
  output logic [NGPIO-1:0]        gpio_oe,
  output logic                    irq
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_t;

  apb_state_t state, state_next;
  logic       pready_next;

  logic [NGPIO-1:0] out_reg, dir_reg, rise_en, fall_en, status, irq_mask;
  logic [SYNC_STAGES-1:0][NGPIO-1:0] sync_ff;
  logic [NGPIO-1:0] sync_prev, pin_sync, edge_set, status_clr;
  logic [NGPIO-1:0] wmask, wbits, rd_sel;
  logic [PDATA_SIZE-1:0] strb_mask, rd_word;
  logic [2:0] reg_idx;
  logic       addr_ok, xfer_done, wr_en;
  logic       unused_bits;

  function automatic logic [NGPIO-1:0] merge_lanes(input logic [NGPIO-1:0] cur,
                                                   input logic [NGPIO-1:0] data,
                                                   input logic [NGPIO-1:0] mask);
    return (cur & ~mask) | (data & mask);
  endfunction

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state  <= IDLE;
      PREADY <= 1'b0;
    end else begin
      state  <= state_next;
      PREADY <= pready_next;
    end
  end

  // PREADY rises entering ACCESS, so every transfer sees exactly one wait state.
  always_comb begin
    state_next  = state;
    pready_next = 1'b0;
    case (state)
      IDLE:    if (PSEL1 && !PENABLE) state_next = SETUP;
      SETUP: begin
        if (PSEL1 && PENABLE) begin
          state_next  = ACCESS;
          pready_next = 1'b1;
        end else if (!PSEL1) begin
          state_next = IDLE;
        end
      end
      ACCESS:  state_next = (PSEL1 && !PENABLE) ? SETUP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign reg_idx   = PADDR[4:2];
  assign addr_ok   = (PADDR[1:0] == 2'b00) && (reg_idx != 3'd7);
  assign xfer_done = PREADY && PSEL1 && PENABLE;
  assign wr_en     = xfer_done && PWRITE && addr_ok;

  always_comb begin
    strb_mask = '0;
    for (int i = 0; i < PDATA_SIZE/8; i++) strb_mask[8*i +: 8] = {8{PSTRB[i]}};
  end

  assign wmask      = strb_mask[NGPIO-1:0];
  assign wbits      = PWDATA[NGPIO-1:0];
  assign status_clr = (wr_en && reg_idx == 3'd5) ? (wbits & wmask) : '0;

  assign pin_sync = sync_ff[SYNC_STAGES-1];
  assign edge_set = (pin_sync & ~sync_prev & rise_en) | (~pin_sync & sync_prev & fall_en);

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      sync_ff   <= '0;
      sync_prev <= '0;
    end else begin
      sync_ff   <= {sync_ff[SYNC_STAGES-2:0], gpio_in};
      sync_prev <= pin_sync;
    end
  end

  // A fresh edge is ORed in after the W1C clear so that set wins a collision.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      out_reg  <= '0;
      dir_reg  <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      status   <= '0;
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_en) begin
        case (reg_idx)
          3'd1:    out_reg  <= merge_lanes(out_reg, wbits, wmask);
          3'd2:    dir_reg  <= merge_lanes(dir_reg, wbits, wmask);
          3'd3:    rise_en  <= merge_lanes(rise_en, wbits, wmask);
          3'd4:    fall_en  <= merge_lanes(fall_en, wbits, wmask);
          3'd6:    irq_mask <= merge_lanes(irq_mask, wbits, wmask);
          default: ;
        endcase
      end
      status <= (status & ~status_clr) | edge_set;
      irq    <= |(status & irq_mask);
    end
  end

  always_comb begin
    rd_sel = '0;
    case (reg_idx)
      3'd0:    rd_sel = pin_sync;
      3'd1:    rd_sel = out_reg;
      3'd2:    rd_sel = dir_reg;
      3'd3:    rd_sel = rise_en;
      3'd4:    rd_sel = fall_en;
      3'd5:    rd_sel = status;
      3'd6:    rd_sel = irq_mask;
      default: rd_sel = '0;
    endcase
    rd_word = '0;
    rd_word[NGPIO-1:0] = rd_sel;
  end

  assign PRDATA   = (PREADY && !PWRITE && addr_ok) ? rd_word : '0;
  assign PSLVERR  = PREADY && !addr_ok;
  assign gpio_out = out_reg;
  assign gpio_oe  = dir_reg;

  assign unused_bits = ^{PADDR[PDATA_SIZE-1:5], PWDATA, strb_mask};

endmodule

// File: tb/tb_apb_gpio_v2.sv
// Self-checking bench for apb_gpio_v2: read expectations are queued when a
// transfer is launched and popped when the DUT completes it.
module tb_apb_gpio_v2;

  logic        PCLK = 1'b0;
  logic        PRESETn, PSEL1, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR, irq;
  logic [31:0] gpio_in, gpio_out, gpio_oe;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  apb_gpio_v2 #(.PDATA_SIZE(32), .NGPIO(32), .SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL1(PSEL1), .PENABLE(PENABLE),
    .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input bit chained,
                          output logic [31:0] rdata, output logic err);
    bit done;
    if (!chained) begin @(posedge PCLK); #1; end
    PSEL1 = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    done = 1'b0; rdata = '0; err = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) begin
        done = 1'b1; rdata = PRDATA; err = PSLVERR;
      end
    end
    if (!done) begin
      tests_run++; tests_failed++;
      $display("[TB] FAIL pready_timeout: addr %h got no PREADY, required within 8 cycles", addr);
    end
    @(posedge PCLK); #1;
    PSEL1 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic err);
    logic [31:0] unused_rd;
    apb_xfer(1'b1, addr, data, strb, 1'b0, unused_rd, err);
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] rdata, output logic err);
    apb_xfer(1'b0, addr, 32'h0, 4'h0, 1'b0, rdata, err);
  endtask

  task automatic test_reset;
    logic [31:0] rd, exp;
    logic err;
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    tests_run++;
    if ({PREADY, PSLVERR, irq} !== 3'b000) begin
      tests_failed++; $display("[TB] FAIL reset_ctrl: got %b required 000", {PREADY, PSLVERR, irq});
    end
    tests_run++;
    if ({PRDATA, gpio_out, gpio_oe} !== 96'h0) begin
      tests_failed++; $display("[TB] FAIL reset_data: got %h/%h/%h required 0", PRDATA, gpio_out, gpio_oe);
    end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    for (int a = 0; a <= 'h18; a += 4) begin
      exp_q.push_back(32'h0);
      apb_read(a, rd, err);
      exp = exp_q.pop_front();
      tests_run++;
      if (rd !== exp || err !== 1'b0) begin
        tests_failed++; $display("[TB] FAIL reset_reg_%0h: got %h err %b required %h err 0", a, rd, err, exp);
      end
    end
  endtask

  task automatic test_byte_strobe;
    logic [31:0] rd, exp;
    logic err;
    apb_write(32'h04, 32'hA5A5_5A5A, 4'b0101, err);
    exp_q.push_back(32'h00A5_005A);
    apb_read(32'h04, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp) begin
      tests_failed++; $display("[TB] FAIL strobe_0101: got %h required %h", rd, exp);
    end
    @(negedge PCLK);
    tests_run++;
    if (gpio_out !== 32'h00A5_005A) begin
      tests_failed++; $display("[TB] FAIL strobe_gpio_out: got %h required 00a5005a", gpio_out);
    end
    apb_write(32'h04, 32'h1122_3344, 4'b1010, err);
    exp_q.push_back(32'h11A5_335A);
    apb_read(32'h04, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp) begin
      tests_failed++; $display("[TB] FAIL strobe_1010: got %h required %h", rd, exp);
    end
  endtask

  task automatic test_in_dir;
    logic [31:0] rd, exp;
    logic err;
    apb_write(32'h08, 32'hFFFF_0000, 4'hF, err);
    @(posedge PCLK); #1;
    gpio_in = 32'h1234_5678;
    repeat (3) @(posedge PCLK);
    exp_q.push_back(32'h1234_5678);
    apb_read(32'h00, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp) begin
      tests_failed++; $display("[TB] FAIL in_read: got %h required %h", rd, exp);
    end
    @(negedge PCLK);
    tests_run++;
    if (gpio_oe !== 32'hFFFF_0000) begin
      tests_failed++; $display("[TB] FAIL dir_gpio_oe: got %h required ffff0000", gpio_oe);
    end
  endtask

  task automatic test_edge_irq;
    logic [31:0] rd, exp;
    logic err;
    gpio_in = 32'h0;
    repeat (4) @(posedge PCLK);
    apb_write(32'h0C, 32'h8, 4'hF, err);
    apb_write(32'h18, 32'h8, 4'hF, err);
    apb_write(32'h10, 32'h1, 4'hF, err);
    exp_q.push_back(32'h0);
    apb_read(32'h14, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp) begin
      tests_failed++; $display("[TB] FAIL status_idle: got %h required %h", rd, exp);
    end
    @(posedge PCLK); #1;
    gpio_in[3] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge PCLK); @(negedge PCLK);
      tests_run++;
      if (irq !== (k == 4)) begin
        tests_failed++; $display("[TB] FAIL irq_latency_%0d: got %b required %b", k, irq, (k == 4));
      end
    end
    exp_q.push_back(32'h8);
    apb_read(32'h14, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp) begin
      tests_failed++; $display("[TB] FAIL status_rise: got %h required %h", rd, exp);
    end
    apb_write(32'h14, 32'h8, 4'hF, err);
    @(negedge PCLK);
    tests_run++;
    if (irq !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL irq_after_w1c_1: got %b required 1", irq);
    end
    @(posedge PCLK); @(negedge PCLK);
    tests_run++;
    if (irq !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL irq_after_w1c_2: got %b required 0", irq);
    end
    @(posedge PCLK); #1;
    gpio_in[0] = 1'b1;
    repeat (4) @(posedge PCLK);
    exp_q.push_back(32'h0);
    apb_read(32'h14, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp) begin
      tests_failed++; $display("[TB] FAIL status_rise_disabled: got %h required %h", rd, exp);
    end
    @(posedge PCLK); #1;
    gpio_in[0] = 1'b0;
    repeat (4) @(posedge PCLK);
    exp_q.push_back(32'h1);
    apb_read(32'h14, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp || irq !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL status_fall: got %h irq %b required %h irq 0", rd, irq, exp);
    end
    apb_write(32'h14, 32'h1, 4'hF, err);
  endtask

  task automatic test_w1c_collision;
    logic [31:0] rd, exp;
    logic err;
    @(posedge PCLK); #1;
    gpio_in[3] = 1'b0;
    repeat (4) @(posedge PCLK);
    #1 gpio_in[3] = 1'b1;
    repeat (4) @(posedge PCLK);
    exp_q.push_back(32'h8);
    apb_read(32'h14, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp) begin
      tests_failed++; $display("[TB] FAIL collision_pre: got %h required %h", rd, exp);
    end
    gpio_in[3] = 1'b0;
    repeat (4) @(posedge PCLK);
    fork
      apb_write(32'h14, 32'h8, 4'hF, err);
      begin @(posedge PCLK); #1; gpio_in[3] = 1'b1; end
    join
    exp_q.push_back(32'h8);
    apb_read(32'h14, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp || irq !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL collision_set_wins: got %h irq %b required %h irq 1", rd, irq, exp);
    end
    apb_write(32'h14, 32'h8, 4'hF, err);
    exp_q.push_back(32'h0);
    apb_read(32'h14, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp) begin
      tests_failed++; $display("[TB] FAIL collision_clear: got %h required %h", rd, exp);
    end
  endtask

  task automatic test_errors;
    logic [31:0] rd, exp;
    logic err;
    apb_read(32'h1C, rd, err);
    tests_run++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL err_read_1c: got err %b data %h required err 1 data 0", err, rd);
    end
    apb_read(32'h05, rd, err);
    tests_run++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL err_read_05: got err %b data %h required err 1 data 0", err, rd);
    end
    apb_write(32'h05, 32'hFFFF_FFFF, 4'hF, err);
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++; $display("[TB] FAIL err_write_05: got err %b required 1", err);
    end
    apb_write(32'h1C, 32'hFFFF_FFFF, 4'hF, err);
    apb_write(32'h00, 32'hFFFF_FFFF, 4'hF, err);
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL in_write_no_err: got err %b required 0", err);
    end
    @(posedge PCLK); #1;
    PSEL1 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h04; PWDATA = 32'h0; PSTRB = 4'hF;
    repeat (3) @(posedge PCLK);
    #1 PSEL1 = 1'b0; PWRITE = 1'b0;
    @(negedge PCLK);
    tests_run++;
    if (PRDATA !== 32'h0) begin
      tests_failed++; $display("[TB] FAIL prdata_idle: got %h required 0", PRDATA);
    end
    exp_q.push_back(32'h11A5_335A);
    apb_read(32'h04, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp || err !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL err_out_unchanged: got %h err %b required %h err 0", rd, err, exp);
    end
    exp_q.push_back(32'h0000_0008);
    apb_read(32'h00, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp) begin
      tests_failed++; $display("[TB] FAIL in_write_ignored: got %h required %h", rd, exp);
    end
    exp_q.push_back(32'h8);
    apb_read(32'h18, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp) begin
      tests_failed++; $display("[TB] FAIL err_mask_unchanged: got %h required %h", rd, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd, exp;
    logic err;
    apb_xfer(1'b1, 32'h18, 32'h0000_00C3, 4'hF, 1'b0, rd, err);
    exp_q.push_back(32'h0000_00C3);
    exp_q.push_back(32'hFFFF_0000);
    exp_q.push_back(32'h11A5_335A);
    apb_xfer(1'b0, 32'h18, 32'h0, 4'h0, 1'b1, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp) begin
      tests_failed++; $display("[TB] FAIL b2b_mask: got %h required %h", rd, exp);
    end
    apb_xfer(1'b0, 32'h08, 32'h0, 4'h0, 1'b1, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp) begin
      tests_failed++; $display("[TB] FAIL b2b_dir: got %h required %h", rd, exp);
    end
    apb_xfer(1'b0, 32'h04, 32'h0, 4'h0, 1'b1, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp) begin
      tests_failed++; $display("[TB] FAIL b2b_out: got %h required %h", rd, exp);
    end
  endtask

  task automatic test_reset_midwrite;
    logic [31:0] rd, exp;
    logic err;
    bit done;
    @(posedge PCLK); #1;
    PSEL1 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'h0000_FFFF; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge PCLK);
      if (PREADY === 1'b1) done = 1'b1;
    end
    tests_run++;
    if (!done) begin
      tests_failed++; $display("[TB] FAIL midwrite_access: got no PREADY, required within 8 cycles");
    end
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    PSEL1 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(negedge PCLK);
    tests_run++;
    if ({PREADY, PSLVERR, irq, PRDATA, gpio_out, gpio_oe} !== 99'h0) begin
      tests_failed++;
      $display("[TB] FAIL midwrite_outputs: got %b%b%b %h %h %h required all 0",
               PREADY, PSLVERR, irq, PRDATA, gpio_out, gpio_oe);
    end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    exp_q.push_back(32'h0);
    apb_read(32'h08, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp) begin
      tests_failed++; $display("[TB] FAIL midwrite_dir: got %h required %h", rd, exp);
    end
    exp_q.push_back(32'h0);
    apb_read(32'h04, rd, err);
    exp = exp_q.pop_front();
    tests_run++;
    if (rd !== exp) begin
      tests_failed++; $display("[TB] FAIL midwrite_out: got %h required %h", rd, exp);
    end
  endtask

  initial begin
    PRESETn = 1'b0; PSEL1 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; gpio_in = '0;
    test_reset;
    test_byte_strobe;
    test_in_dir;
    test_edge_irq;
    test_w1c_collision;
    test_errors;
    test_back_to_back;
    test_reset_midwrite;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++; $display("[TB] FAIL scoreboard_drain: got %0d entries left required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
